// File: rtl/nn_frame_loader.sv
// Buffers a byte-serial network frame, replays it to neural_network in load order,
// then captures the network output after a fixed settling wait.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | ready for the first byte of a frame
// FILL    | accepting the remaining bytes of the frame
// PLAY_X  | replaying input bytes, changes on x[0]
// PLAY_P  | replaying parameter bytes from the buffer
// COMMIT  | single changes strobe to latch the loaded parameters
// WAIT    | settling time before sampling network_outputs
// CAPTURE | result registered, result_valid pulse
module nn_frame_loader #(
  parameter int N_INPUTS    = 4,
  parameter int N_NEURONS   = 4,
  parameter int DATA_W      = 8,
  parameter int RESULT_WAIT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic              keep_params,
  output logic [DATA_W-1:0] nn_data_in,
  output logic              nn_changes,
  input  logic [DATA_W-1:0] nn_outputs,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              busy
);

  localparam int P_LEN     = N_NEURONS * (N_INPUTS + 2);
  localparam int FRAME_LEN = N_INPUTS + P_LEN;
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam int WAIT_W    = (RESULT_WAIT > 1) ? $clog2(RESULT_WAIT) : 1;
  localparam logic [IDX_W-1:0]  X_LAST = IDX_W'(N_INPUTS - 1);
  localparam logic [IDX_W-1:0]  F_LAST = IDX_W'(FRAME_LEN - 1);
  localparam logic [WAIT_W-1:0] W_LOAD = WAIT_W'(RESULT_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE, FILL, PLAY_X, PLAY_P, COMMIT, WAIT, CAPTURE
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] buffer [FRAME_LEN];
  logic [IDX_W-1:0]  wr_idx, last_idx, play_idx, first_last, wr_ptr;
  logic [WAIT_W-1:0] wait_cnt;
  logic              params_loaded, accept;

  assign accept     = s_valid && s_ready;
  // Inputs-only frames are only honoured once a full parameter set is held.
  assign first_last = (keep_params && params_loaded) ? X_LAST : F_LAST;
  assign wr_ptr     = (state == IDLE) ? '0 : wr_idx;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (first_last == '0) ? PLAY_X : FILL;
      FILL:    if (accept && wr_idx == last_idx) state_nxt = PLAY_X;
      PLAY_X:  if (play_idx == X_LAST) state_nxt = PLAY_P;
      PLAY_P:  if (play_idx == F_LAST) state_nxt = COMMIT;
      COMMIT:  state_nxt = WAIT;
      WAIT:    if (wait_cnt == '0) state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx        <= '0;
      last_idx      <= '0;
      play_idx      <= '0;
      wait_cnt      <= '0;
      params_loaded <= 1'b0;
      result        <= '0;
    end else begin
      if (state == IDLE && accept) begin
        last_idx <= first_last;
        wr_idx   <= IDX_W'(1);
      end else if (state == FILL && accept) begin
        if (wr_idx != last_idx) wr_idx <= wr_idx + IDX_W'(1);
        else if (last_idx == F_LAST) params_loaded <= 1'b1;
      end

      if (state == IDLE || state == FILL)
        play_idx <= '0;
      else if ((state == PLAY_X || state == PLAY_P) && play_idx != F_LAST)
        play_idx <= play_idx + IDX_W'(1);

      if (state == COMMIT)
        wait_cnt <= W_LOAD;
      else if (state == WAIT && wait_cnt != '0)
        wait_cnt <= wait_cnt - WAIT_W'(1);

      if (state == WAIT && wait_cnt == '0)
        result <= nn_outputs;
    end
  end

  // Buffer is deliberately unreset; only the frame bytes themselves matter.
  always_ff @(posedge clk) begin
    if (accept) buffer[wr_ptr] <= s_data;
  end

  always_comb begin
    s_ready      = !reset && (state == IDLE || state == FILL);
    busy         = (state != IDLE);
    result_valid = (state == CAPTURE);
    nn_data_in   = '0;
    nn_changes   = 1'b0;
    case (state)
      PLAY_X: begin
        nn_data_in = buffer[play_idx];
        nn_changes = (play_idx == X_LAST);
      end
      PLAY_P:  nn_data_in = buffer[play_idx];
      COMMIT:  nn_changes = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nn_frame_loader.sv
// Randomized bench for nn_frame_loader: a frame-level model predicts the replay
// sequence, strobe cycles and captured result for two RESULT_WAIT builds.
module tb_nn_frame_loader;

  localparam int N_INPUTS  = 4;
  localparam int N_NEURONS = 4;
  localparam int DATA_W    = 8;
  localparam int P_LEN     = N_NEURONS * (N_INPUTS + 2);
  localparam int FRAME_LEN = N_INPUTS + P_LEN;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              keep_params;
  logic [DATA_W-1:0] s_data;
  logic              s_valid0, s_valid1;
  logic [DATA_W-1:0] nn_out0, nn_out1;
  logic              s_ready0, s_ready1;
  logic [DATA_W-1:0] nn_data_in0, nn_data_in1;
  logic              nn_changes0, nn_changes1;
  logic [DATA_W-1:0] result0, result1;
  logic              result_valid0, result_valid1;
  logic              busy0, busy1;

  nn_frame_loader #(.N_INPUTS(N_INPUTS), .N_NEURONS(N_NEURONS), .DATA_W(DATA_W),
                    .RESULT_WAIT(2)) dut0 (
    .clk(clk), .reset(reset), .s_valid(s_valid0), .s_data(s_data), .s_ready(s_ready0),
    .keep_params(keep_params), .nn_data_in(nn_data_in0), .nn_changes(nn_changes0),
    .nn_outputs(nn_out0), .result(result0), .result_valid(result_valid0), .busy(busy0));

  nn_frame_loader #(.N_INPUTS(N_INPUTS), .N_NEURONS(N_NEURONS), .DATA_W(DATA_W),
                    .RESULT_WAIT(1)) dut1 (
    .clk(clk), .reset(reset), .s_valid(s_valid1), .s_data(s_data), .s_ready(s_ready1),
    .keep_params(keep_params), .nn_data_in(nn_data_in1), .nn_changes(nn_changes1),
    .nn_outputs(nn_out1), .result(result1), .result_valid(result_valid1), .busy(busy1));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: buffer image, parameter-held flag and last result per build.
  logic [DATA_W-1:0] mem0 [FRAME_LEN];
  logic [DATA_W-1:0] mem1 [FRAME_LEN];
  bit                loaded [2];
  logic [DATA_W-1:0] res_model [2];
  logic [DATA_W-1:0] frame [FRAME_LEN];

  function automatic logic [31:0] o_ready(int sel);
    return 32'(sel != 0 ? s_ready1 : s_ready0);
  endfunction
  function automatic logic [31:0] o_data(int sel);
    return 32'(sel != 0 ? nn_data_in1 : nn_data_in0);
  endfunction
  function automatic logic [31:0] o_chg(int sel);
    return 32'(sel != 0 ? nn_changes1 : nn_changes0);
  endfunction
  function automatic logic [31:0] o_rv(int sel);
    return 32'(sel != 0 ? result_valid1 : result_valid0);
  endfunction
  function automatic logic [31:0] o_res(int sel);
    return 32'(sel != 0 ? result1 : result0);
  endfunction
  function automatic logic [31:0] o_busy(int sel);
    return 32'(sel != 0 ? busy1 : busy0);
  endfunction

  task automatic drive(input int sel, input logic v, input logic [DATA_W-1:0] nn);
    if (sel != 0) begin s_valid1 = v; nn_out1 = nn; end
    else          begin s_valid0 = v; nn_out0 = nn; end
  endtask

  task automatic model_reset();
    loaded[0] = 1'b0; loaded[1] = 1'b0;
    res_model[0] = '0; res_model[1] = '0;
  endtask

  // nn_mode: 0 holds A5, 1 random every cycle, 2 random with 3C on the last WAIT cycle.
  task automatic run_frame(input int sel, input bit keep, input bit bubbles,
                           input bit hold, input int nn_mode, input int abort_at);
    int len, cap, i;
    bit phase;
    logic [DATA_W-1:0] nn_val, exp_d;
    len   = (keep && loaded[sel]) ? N_INPUTS : FRAME_LEN;
    cap   = FRAME_LEN + 1 + ((sel != 0) ? 1 : 2);
    i     = 0;
    phase = 1'b0;
    while (i < len) begin
      @(negedge clk);
      chk("s_ready_fill", o_ready(sel), 32'd1);
      nn_val = (nn_mode == 0) ? 8'hA5 : 8'($urandom);
      if (bubbles && phase) begin
        drive(sel, 1'b0, nn_val);
        s_data      = 8'($urandom);
        keep_params = 1'($urandom);
      end else begin
        drive(sel, 1'b1, nn_val);
        s_data      = frame[i];
        keep_params = (i == 0) ? keep : 1'($urandom);
        i++;
      end
      phase = ~phase;
    end
    for (int k = 0; k < len; k++) begin
      if (sel != 0) mem1[k] = frame[k];
      else          mem0[k] = frame[k];
    end
    if (len == FRAME_LEN) loaded[sel] = 1'b1;

    for (int c = 0; c <= cap; c++) begin
      @(negedge clk);
      if (abort_at >= 0 && c == abort_at + 1) begin
        chk("abort_data", o_data(sel), 32'd0);
        chk("abort_changes", o_chg(sel), 32'd0);
        chk("abort_busy", o_busy(sel), 32'd0);
        chk("abort_rv", o_rv(sel), 32'd0);
        reset = 1'b0;
        drive(sel, 1'b0, 8'($urandom));
        model_reset();
        for (int k = 0; k < cap; k++) begin
          @(negedge clk);
          chk("abort_no_rv", o_rv(sel), 32'd0);
          chk("abort_idle", o_busy(sel), 32'd0);
        end
        chk("abort_result", o_res(sel), 32'(res_model[sel]));
        return;
      end
      exp_d = (c < FRAME_LEN) ? ((sel != 0) ? mem1[c] : mem0[c]) : '0;
      chk("nn_data_in", o_data(sel), 32'(exp_d));
      chk("nn_changes", o_chg(sel), 32'(c == N_INPUTS - 1 || c == FRAME_LEN));
      chk("result_valid", o_rv(sel), 32'(c == cap));
      chk("s_ready_play", o_ready(sel), 32'd0);
      chk("busy_play", o_busy(sel), 32'd1);
      if (c == cap) chk("result", o_res(sel), 32'(res_model[sel]));
      case (nn_mode)
        0:       nn_val = 8'hA5;
        2:       nn_val = (c == cap - 1) ? 8'h3C : 8'($urandom);
        default: nn_val = 8'($urandom);
      endcase
      if (c == cap - 1) res_model[sel] = nn_val;
      drive(sel, hold && (c < cap), nn_val);
      s_data      = 8'($urandom);
      keep_params = 1'($urandom);
      if (c == abort_at) reset = 1'b1;
    end
    @(negedge clk);
    chk("idle_busy", o_busy(sel), 32'd0);
    chk("idle_ready", o_ready(sel), 32'd1);
    chk("idle_rv", o_rv(sel), 32'd0);
    chk("result_hold", o_res(sel), 32'(res_model[sel]));
  endtask

  task automatic rand_frame();
    for (int k = 0; k < FRAME_LEN; k++) frame[k] = 8'($urandom);
  endtask

  task automatic spec_frame();
    for (int k = 0; k < N_INPUTS; k++) frame[k] = 8'(10 - k);
    for (int n = 0; n < N_NEURONS; n++) begin
      for (int k = 0; k < N_INPUTS + 2; k++) begin
        if (k == 0)                 frame[N_INPUTS + n*(N_INPUTS+2) + k] = 8'd0;
        else if (n == N_NEURONS-1)  frame[N_INPUTS + n*(N_INPUTS+2) + k] = 8'd1;
        else                        frame[N_INPUTS + n*(N_INPUTS+2) + k] = 8'(N_INPUTS + 2 - k);
      end
    end
  endtask

  initial begin
    reset = 1'b1; keep_params = 1'b0; s_data = '0;
    s_valid0 = 1'b0; s_valid1 = 1'b0; nn_out0 = '0; nn_out1 = '0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      chk("s_ready_in_reset0", 32'(s_ready0), 32'd0);
      chk("s_ready_in_reset1", 32'(s_ready1), 32'd0);
    end
    reset = 1'b0;
    #1;
    chk("s_ready_release", 32'(s_ready0), 32'd1);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_busy", o_busy(s), 32'd0);
      chk("rst_data", o_data(s), 32'd0);
      chk("rst_changes", o_chg(s), 32'd0);
      chk("rst_rv", o_rv(s), 32'd0);
      chk("rst_result", o_res(s), 32'd0);
    end

    // keep_params right after reset still needs a full frame
    rand_frame();  run_frame(0, 1'b1, 1'b0, 1'b0, 1, -1);
    spec_frame();  run_frame(0, 1'b0, 1'b0, 1'b0, 0, -1);
    spec_frame();  run_frame(0, 1'b0, 1'b1, 1'b1, 0, -1);
    frame[0] = 8'd20; frame[1] = 8'd21; frame[2] = 8'd22; frame[3] = 8'd23;
    run_frame(0, 1'b1, 1'b0, 1'b0, 1, -1);
    for (int r = 0; r < 6; r++) begin
      rand_frame();
      run_frame(0, 1'($urandom), 1'($urandom), 1'($urandom), 1, -1);
    end

    rand_frame();  run_frame(0, 1'b0, 1'b0, 1'b0, 1, 10);
    rand_frame();  run_frame(0, 1'b1, 1'b1, 1'b0, 1, -1);
    rand_frame();  run_frame(0, 1'b1, 1'b0, 1'b1, 1, -1);

    spec_frame();  run_frame(1, 1'b0, 1'b0, 1'b0, 2, -1);
    rand_frame();  run_frame(1, 1'b1, 1'b1, 1'b1, 2, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
